// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes, RAM-slave FSM encoding and the byte-lane merge helper.
// The RMW states are only reachable when TL_PARTIAL_WRITE_EN is defined.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RESP    = 3'd2,
        ST_RMW_RD  = 3'd3,
        ST_RMW_WR  = 3'd4
    } state_e;

    // Lane k of the result comes from new_w when mask[k] is set, else from old_w.
    function automatic logic [63:0] merge_mask64(input logic [63:0] old_w,
                                                 input logic [63:0] new_w,
                                                 input logic [7:0]  mask);
        logic [63:0] r;
        r = old_w;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_ul_ram_slave_if.sv
// TileLink-UL channel A / channel D bundle between a master and the RAM slave front-end.
interface tl_ul_ram_slave_if #(
    parameter int SRC_W = 4
);
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [31:0]      a_address;
    logic [7:0]       a_mask;
    logic [63:0]      a_data;

    logic             d_valid;
    logic             d_ready;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [63:0]      d_data;
    logic             d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_ul_ram_slave.sv
// TileLink-UL slave front-end for a 64-bit, 1-cycle-latency RAM; one transaction in flight.
// Define TL_PARTIAL_WRITE_EN to service PutPartialData by read-modify-write; otherwise it is denied.
module tl_ul_ram_slave
    import tl_ul_pkg::*;
#(
    parameter int SRC_W     = 4,
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    tl_ul_ram_slave_if.slave tl,
    output logic        o_wen,
    output logic [31:0] o_write_address,
    output logic [63:0] o_wdata,
    output logic        o_ren,
    output logic [31:0] o_read_address,
    input  logic [63:0] i_rdata
);

    state_e           state_q, state_d;
    logic [SRC_W-1:0] src_q;
    logic [2:0]       size_q;
    logic [2:0]       opc_q;
    logic             denied_q;
    logic [31:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [63:0]      d_data_q;
    logic             wen_q;
    logic             fresh_q;

    logic             a_ready, d_valid, accept;
    logic             addr_ok, size_ok, get_ok, putf_ok, part_ok;
    logic [32:0]      end_addr;
    logic             unused_in;

    // Widened so an address near 4 GiB cannot wrap back into range.
    assign end_addr = {1'b0, tl.a_address} + 33'd8;
    assign addr_ok  = (tl.a_address[2:0] == 3'b000) && (end_addr <= 33'(MEM_BYTES));
    assign size_ok  = (tl.a_size <= 3'd3);
    assign get_ok   = (tl.a_opcode == GET) && addr_ok && size_ok;
    assign putf_ok  = (tl.a_opcode == PUT_FULL) && addr_ok && (tl.a_size == 3'd3);
`ifdef TL_PARTIAL_WRITE_EN
    logic [7:0] mask_q;
    assign part_ok  = (tl.a_opcode == PUT_PARTIAL) && addr_ok && size_ok;
`else
    assign part_ok  = 1'b0;
`endif
    assign accept    = tl.a_valid && a_ready;
    assign unused_in = ^{tl.a_param, tl.a_mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (get_ok)       state_d = ST_RD_WAIT;
                    else if (part_ok) state_d = ST_RMW_RD;
                    else              state_d = ST_RESP;
                end
            end
            ST_RD_WAIT: state_d = ST_RESP;
            ST_RESP:    if (tl.d_ready) state_d = ST_IDLE;
`ifdef TL_PARTIAL_WRITE_EN
            ST_RMW_RD:  state_d = ST_RMW_WR;
            ST_RMW_WR:  state_d = ST_RESP;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_ready = 1'b0;
        d_valid = 1'b0;
        o_ren   = 1'b0;
        o_wen   = 1'b0;
        o_wdata = wdata_q;
        case (state_q)
            ST_IDLE:    a_ready = 1'b1;
            ST_RD_WAIT: o_ren   = 1'b1;
            ST_RESP: begin
                d_valid = 1'b1;
                o_wen   = wen_q;
            end
`ifdef TL_PARTIAL_WRITE_EN
            ST_RMW_RD:  o_ren   = 1'b1;
            ST_RMW_WR: begin
                o_wen   = 1'b1;
                o_wdata = merge_mask64(i_rdata, wdata_q, mask_q);
            end
`endif
            default: ;
        endcase
    end

    // Response register bank. A Get enters RESP while its read word is still on
    // i_rdata; fresh_q forwards it for that first cycle and the register holds it after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q    <= '0;
            size_q   <= '0;
            opc_q    <= '0;
            denied_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            d_data_q <= '0;
            wen_q    <= 1'b0;
            fresh_q  <= 1'b0;
`ifdef TL_PARTIAL_WRITE_EN
            mask_q   <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            if (accept) begin
                src_q    <= tl.a_source;
                size_q   <= tl.a_size;
                opc_q    <= (tl.a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
                denied_q <= !(get_ok || putf_ok || part_ok);
                addr_q   <= tl.a_address;
                wdata_q  <= tl.a_data;
                d_data_q <= '0;
                wen_q    <= putf_ok;
                fresh_q  <= 1'b0;
`ifdef TL_PARTIAL_WRITE_EN
                mask_q   <= tl.a_mask;
`endif
            end else if (state_q == ST_RD_WAIT) begin
                fresh_q <= 1'b1;
            end else if (fresh_q) begin
                d_data_q <= i_rdata;
                fresh_q  <= 1'b0;
            end
        end
    end

    assign o_write_address = addr_q;
    assign o_read_address  = addr_q;

    assign tl.a_ready   = a_ready;
    assign tl.d_valid   = d_valid;
    assign tl.d_opcode  = opc_q;
    assign tl.d_param   = 2'b00;
    assign tl.d_size    = size_q;
    assign tl.d_source  = src_q;
    assign tl.d_denied  = denied_q;
    assign tl.d_data    = fresh_q ? i_rdata : d_data_q;
    assign tl.d_corrupt = 1'b0;

endmodule
